// File: rtl/window_scheduler.sv
// Raster-scan 3x3 window sequencer: buffers two lines in a shift chain, emits one
// zero-masked neighbourhood plus kernel-select code per pixel, then drains the frame tail.
module window_scheduler #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 4,
   parameter int IMG_HEIGHT = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] line0_data0,
   output logic [DATA_WIDTH-1:0] line0_data1,
   output logic [DATA_WIDTH-1:0] line0_data2,
   output logic [DATA_WIDTH-1:0] line1_data0,
   output logic [DATA_WIDTH-1:0] line1_data1,
   output logic [DATA_WIDTH-1:0] line1_data2,
   output logic [DATA_WIDTH-1:0] line2_data0,
   output logic [DATA_WIDTH-1:0] line2_data1,
   output logic [DATA_WIDTH-1:0] line2_data2,
   output logic [3:0]            corner_type,
   output logic                  frame_done
);

   // state | meaning
   // IDLE  | waiting for frame_start, no handshakes
   // FILL  | accepting the first W+1 pixels, no windows yet
   // RUN   | one window per accepted pixel
   // FLUSH | shifting W+1 zero pixels to drain the last windows

   localparam int CHAIN = 2*IMG_WIDTH + 3;
   localparam int CW    = $clog2(IMG_WIDTH);
   localparam int RW    = $clog2(IMG_HEIGHT);
   localparam int FW    = $clog2(IMG_WIDTH + 2);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [FW-1:0] FL_INIT  = FW'(IMG_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   state_t                             state_q;
   logic [CHAIN-1:0][DATA_WIDTH-1:0]   chain_q;
   logic [CHAIN-1:0][DATA_WIDTH-1:0]   chain_d;
   logic [8:0][DATA_WIDTH-1:0]         win_q;
   logic [8:0][DATA_WIDTH-1:0]         win_d;
   logic [3:0]                         corner_q;
   logic [3:0]                         corner_d;
   logic                               out_valid_q;
   logic                               frame_done_q;
   logic [CW-1:0]                      in_col_q;
   logic [RW-1:0]                      in_row_q;
   logic [CW-1:0]                      win_col_q;
   logic [RW-1:0]                      win_row_q;
   logic [FW-1:0]                      fl_cnt_q;

   logic                  slot_free;
   logic                  accept;
   logic                  flush_shift;
   logic                  load;
   logic                  out_hs;
   logic [DATA_WIDTH-1:0] pix;

   assign slot_free   = !out_valid_q || out_ready;
   assign in_ready    = (state_q == FILL) || ((state_q == RUN) && slot_free);
   assign accept      = in_valid && in_ready;
   assign flush_shift = (state_q == FLUSH) && (fl_cnt_q != '0) && slot_free;
   assign load        = ((state_q == RUN) && accept) || flush_shift;
   assign out_hs      = out_valid_q && out_ready;
   assign pix         = accept ? in_data : '0;
   assign chain_d     = {chain_q[CHAIN-2:0], pix};

   // Newest pixel sits at chain index 0, so the centre of the window being loaded
   // is W+1 pixels back; line K starts (2-K)*W+2 entries into the chain.
   always_comb begin
      logic keep;
      win_d = '0;
      keep  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 3; j++) begin
            keep = !((k == 0 && win_row_q == '0)      ||
                     (k == 2 && win_row_q == ROW_LAST) ||
                     (j == 0 && win_col_q == '0)      ||
                     (j == 2 && win_col_q == COL_LAST));
            if (keep)
               win_d[k*3+j] = chain_d[(2-k)*IMG_WIDTH + 2 - j];
         end
      end
   end

   always_comb begin
      corner_d = 4'd8;
      if (win_col_q == '0)
         corner_d = (win_row_q == '0) ? 4'd1 : (win_row_q == ROW_LAST) ? 4'd5 : 4'd3;
      else if (win_col_q == COL_LAST)
         corner_d = (win_row_q == '0) ? 4'd2 : (win_row_q == ROW_LAST) ? 4'd6 : 4'd4;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         chain_q      <= '0;
         win_q        <= '0;
         corner_q     <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         in_col_q     <= '0;
         in_row_q     <= '0;
         win_col_q    <= '0;
         win_row_q    <= '0;
         fl_cnt_q     <= '0;
      end else begin
         frame_done_q <= 1'b0;

         if (accept || flush_shift)
            chain_q <= chain_d;

         if (accept) begin
            if (in_col_q == COL_LAST) begin
               in_col_q <= '0;
               in_row_q <= (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
            end else begin
               in_col_q <= in_col_q + 1'b1;
            end
         end

         if (load) begin
            win_q       <= win_d;
            corner_q    <= corner_d;
            out_valid_q <= 1'b1;
            if (win_col_q == COL_LAST) begin
               win_col_q <= '0;
               win_row_q <= (win_row_q == ROW_LAST) ? '0 : win_row_q + 1'b1;
            end else begin
               win_col_q <= win_col_q + 1'b1;
            end
         end else if (out_hs) begin
            out_valid_q <= 1'b0;
            corner_q    <= '0;
         end

         if (flush_shift)
            fl_cnt_q <= fl_cnt_q - 1'b1;

         case (state_q)
            IDLE: begin
               if (frame_start) begin
                  state_q   <= FILL;
                  chain_q   <= '0;
                  in_col_q  <= '0;
                  in_row_q  <= '0;
                  win_col_q <= '0;
                  win_row_q <= '0;
               end
            end
            FILL: begin
               if (accept && in_row_q == RW'(1) && in_col_q == '0)
                  state_q <= RUN;
            end
            RUN: begin
               if (accept && in_row_q == ROW_LAST && in_col_q == COL_LAST) begin
                  state_q  <= FLUSH;
                  fl_cnt_q <= FL_INIT;
               end
            end
            FLUSH: begin
               if (fl_cnt_q == '0 && out_hs) begin
                  state_q      <= IDLE;
                  frame_done_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_valid   = out_valid_q;
   assign corner_type = corner_q;
   assign frame_done  = frame_done_q;
   assign line0_data0 = win_q[0];
   assign line0_data1 = win_q[1];
   assign line0_data2 = win_q[2];
   assign line1_data0 = win_q[3];
   assign line1_data1 = win_q[4];
   assign line1_data2 = win_q[5];
   assign line2_data0 = win_q[6];
   assign line2_data1 = win_q[7];
   assign line2_data2 = win_q[8];

endmodule

// File: tb/tb_window_scheduler.sv
// Bench for window_scheduler (W=4, H=3): expected windows are queued per frame from an
// image model and a negedge monitor pops and compares on every output handshake.
module tb_window_scheduler;
   localparam int W = 4;
   localparam int H = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_start = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready, out_valid, frame_done;
   logic [3:0] corner_type;
   logic [7:0] l0d0, l0d1, l0d2, l1d0, l1d1, l1d2, l2d0, l2d1, l2d2;
   logic [8:0][7:0] dut_d;

   window_scheduler #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .line0_data0(l0d0), .line0_data1(l0d1), .line0_data2(l0d2),
      .line1_data0(l1d0), .line1_data1(l1d1), .line1_data2(l1d2),
      .line2_data0(l2d0), .line2_data1(l2d1), .line2_data2(l2d2),
      .corner_type(corner_type), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   assign dut_d = {l2d2, l2d1, l2d0, l1d2, l1d1, l1d0, l0d2, l0d1, l0d0};

   typedef struct packed {
      logic [8:0][7:0] d;
      logic [3:0]      ct;
   } win_t;

   win_t sb[$];
   win_t held;
   int   checks = 0;
   int   errors = 0;
   int   px_acc = 0;
   int   win_idx = 0;
   int   post_cnt = 0;
   int   done_cnt = 0;
   int   done_base = 0;
   bit   stall_prev = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int px(input int r, input int c);
      if (r < 0 || r >= H || c < 0 || c >= W) return 0;
      return r*W + c + 1;
   endfunction

   function automatic win_t exp_win(input int r, input int c);
      win_t e;
      for (int k = 0; k < 3; k++)
         for (int j = 0; j < 3; j++)
            e.d[k*3+j] = 8'(px(r+k-1, c+j-1));
      if (c == 0)          e.ct = (r == 0) ? 4'd1 : (r == H-1) ? 4'd5 : 4'd3;
      else if (c == W-1)   e.ct = (r == 0) ? 4'd2 : (r == H-1) ? 4'd6 : 4'd4;
      else                 e.ct = 4'd8;
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_done) done_cnt++;
         if (out_valid && !out_ready) begin
            if (stall_prev) begin
               chk("stall_data_stable", 32'(dut_d == held.d), 1);
               chk("stall_corner_stable", 32'(corner_type), 32'(held.ct));
            end
            chk("stall_in_ready", 32'(in_ready), 0);
            held.d = dut_d;
            held.ct = corner_type;
            stall_prev = 1;
         end else begin
            stall_prev = 0;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'(sb.size()), 1);
            end else begin
               win_t e;
               e = sb.pop_front();
               for (int i = 0; i < 9; i++)
                  chk($sformatf("win%0d_line%0d_data%0d", win_idx, i/3, i%3),
                      32'(dut_d[i]), 32'(e.d[i]));
               chk($sformatf("win%0d_corner", win_idx), 32'(corner_type), 32'(e.ct));
               if (win_idx >= 6) chk($sformatf("win%0d_flush_in_ready", win_idx), 32'(in_ready), 0);
               if (px_acc == 12) post_cnt++;
               win_idx++;
            end
         end
      end
   end

   task automatic start_frame();
      px_acc = 0;
      win_idx = 0;
      post_cnt = 0;
      done_base = done_cnt;
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
      chk("fill_in_ready", 32'(in_ready), 1);
      chk("fill_out_valid", 32'(out_valid), 0);
   endtask

   task automatic push_frame();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            sb.push_back(exp_win(r, c));
   endtask

   task automatic send_px(input logic [7:0] v);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = v;
      @(negedge clk);
      while (!in_ready && n < 60) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      px_acc++;
   endtask

   task automatic send_frame_pixels(input int count);
      for (int i = 1; i <= count; i++) begin
         send_px(8'(i));
         if (i <= 5) chk($sformatf("fill_no_window_px%0d", i), 32'(out_valid), 0);
         else if (i == 6) chk("first_window_valid", 32'(out_valid), 1);
      end
   endtask

   task automatic end_frame();
      int n;
      n = 0;
      while (done_cnt == done_base && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("frame_done_pulses", 32'(done_cnt - done_base), 1);
      chk("idle_out_valid", 32'(out_valid), 0);
      chk("idle_in_ready", 32'(in_ready), 0);
      chk("all_windows_seen", 32'(sb.size()), 0);
      // window loaded by pixel 12 plus the five flushed ones
      chk("windows_after_last_pixel", 32'(post_cnt), 6);
   endtask

   initial begin
      #12;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_corner", 32'(corner_type), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_window_zero", 32'(dut_d == '0), 1);
      @(posedge clk); #1 rst_n = 1'b1;

      // frame 1: free-flowing output
      out_ready = 1'b1;
      start_frame();
      push_frame();
      send_frame_pixels(12);
      end_frame();

      // frame 2: 5-cycle output stall mid-RUN plus a stray frame_start
      start_frame();
      push_frame();
      fork
         send_frame_pixels(12);
         begin
            wait (px_acc >= 7);
            @(posedge clk); #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk); #1 frame_start = 1'b1;
            @(posedge clk); #1 frame_start = 1'b0;
         end
      join
      end_frame();

      // frame 3: reset after pixel 7, then a clean frame
      start_frame();
      push_frame();
      send_frame_pixels(7);
      chk("pre_reset_out_valid", 32'(out_valid), 1);
      @(negedge clk); #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_in_ready", 32'(in_ready), 0);
      chk("midrst_corner", 32'(corner_type), 0);
      chk("midrst_window_zero", 32'(dut_d == '0), 1);
      sb.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      start_frame();
      push_frame();
      send_frame_pixels(12);
      end_frame();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
